// File: rtl/conv_loader_pkg.sv
// Shared definitions for the conv model load/stream path: loader states and
// the default frame geometry used by the loader, the model and its benches.
package conv_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_SETTLE,
    ST_STREAM,
    ST_DONE
  } loader_state_e;

  // 72 kernel + 4 bias + 1 macc coefficient
  localparam int DEF_WEIGHT_COUNT  = 77;
  // 5x5 frame
  localparam int DEF_IMAGE_SIZE    = 25;
  localparam int DEF_SETTLE_CYCLES = 10;
  localparam int DEF_DATA_W        = 16;
  localparam int DEF_ADDR_W        = 32;

  // Largest of three phase lengths; sizes the shared index counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/conv_stream_loader.sv
// Hardware initiator for the conv model: turns one ready/valid word stream
// into a weight load (addresses 0..WEIGHT_COUNT-1), a settle gap, and a frame
// of pixels, throttled by the downstream FIFO's almost_full.
module conv_stream_loader
  import conv_loader_pkg::*;
#(
  parameter int WEIGHT_COUNT  = DEF_WEIGHT_COUNT,
  parameter int IMAGE_SIZE    = DEF_IMAGE_SIZE,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reload_weights,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              fifo_almost_full,
  output logic              weight_wr_en,
  output logic [ADDR_W-1:0] weight_wr_addr,
  output logic [DATA_W-1:0] weight_wr_data,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  // One counter indexes weights, settle cycles and pixels in turn, so it is
  // sized for the longest of the three phases.
  localparam int CNT_MAX = max3(WEIGHT_COUNT, IMAGE_SIZE, SETTLE_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WEIGHT_COUNT - 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(IMAGE_SIZE - 1);

  loader_state_e    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             weights_loaded, weights_loaded_nxt;
  logic             accept;

  // Ready is open for every load word, gated by almost_full while streaming,
  // and closed everywhere else (including the settle gap).
  always_comb begin
    s_ready = 1'b0;
    if (state == ST_LOAD_W)      s_ready = 1'b1;
    else if (state == ST_STREAM) s_ready = !fifo_almost_full;
  end

  assign accept = s_valid && s_ready;
  assign busy   = (state != ST_IDLE);

  // State, shared counter and weights-loaded flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      weights_loaded <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      weights_loaded <= weights_loaded_nxt;
    end
  end

  // Next-state logic; the counter is cleared on every phase change so each
  // phase starts indexing from zero.
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    weights_loaded_nxt = weights_loaded;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_nxt   = '0;
          state_nxt = (reload_weights || !weights_loaded) ? ST_LOAD_W : ST_STREAM;
        end
      end
      ST_LOAD_W: begin
        if (accept) begin
          if (cnt == W_LAST) begin
            cnt_nxt            = '0;
            weights_loaded_nxt = 1'b1;
            state_nxt          = ST_SETTLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (cnt == S_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_STREAM;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_STREAM: begin
        if (accept) begin
          if (cnt == P_LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_DONE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs: each accepted word appears one cycle later as a weight
  // write or a pixel; address/data hold between strobes. done and the frame
  // counter fire on the cycle after DONE, together with the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_wr_en   <= 1'b0;
      weight_wr_addr <= '0;
      weight_wr_data <= '0;
      i_valid        <= 1'b0;
      i_data         <= '0;
      done           <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      weight_wr_en <= (state == ST_LOAD_W) && accept;
      if ((state == ST_LOAD_W) && accept) begin
        weight_wr_addr <= ADDR_W'(cnt);
        weight_wr_data <= s_data;
      end
      i_valid <= (state == ST_STREAM) && accept;
      if ((state == ST_STREAM) && accept) i_data <= s_data;
      done <= (state == ST_DONE);
      if (state == ST_DONE) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_conv_stream_loader.sv
// Randomized bench for conv_stream_loader against a frame-level reference
// model: each accepted word is assigned its role (weight k / pixel k) from the
// frame rules and the expected outputs are rebuilt every cycle.
module tb_conv_stream_loader;

  localparam int WC = 77, IS = 25, SC = 10, DW = 16, AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1, start = 1'b0, reload_weights = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0, fifo_almost_full = 1'b0;
  logic          s_ready, weight_wr_en, i_valid, busy, done;
  logic [AW-1:0] weight_wr_addr;
  logic [DW-1:0] weight_wr_data, i_data;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  conv_stream_loader #(
    .WEIGHT_COUNT(WC), .IMAGE_SIZE(IS), .SETTLE_CYCLES(SC), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .reload_weights(reload_weights),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fifo_almost_full(fifo_almost_full),
    .weight_wr_en(weight_wr_en), .weight_wr_addr(weight_wr_addr),
    .weight_wr_data(weight_wr_data), .i_valid(i_valid), .i_data(i_data),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which part of a frame we are in and how many words of
  // that part have been consumed.
  typedef enum {P_IDLE, P_LOAD, P_GAP, P_PIX, P_END} phase_t;
  phase_t        ph = P_IDLE;
  bit            m_loaded = 0;
  int            m_n = 0, m_gap = 0;
  logic [AW-1:0] e_waddr = '0;
  logic [DW-1:0] e_wdata = '0, e_idata = '0;
  logic [15:0]   e_fc = '0;

  // Observation log for frame-level checks.
  int cyc = 0, last_wr_cyc = -1, first_pix_cyc = -1, done_seen = 0, n_wr = 0, n_pix = 0;

  // One clock: drive inputs, check ready/busy, clock, update model, check outputs.
  task automatic tick(input bit st, input bit rl, input bit v, input bit af, input bit r,
                      input logic [DW-1:0] d, output bit acc);
    bit e_rdy, e_wen, e_iv, e_done;
    @(negedge clk);
    start = st; reload_weights = rl; s_valid = v; fifo_almost_full = af; rst = r; s_data = d;
    #1;
    e_rdy = (ph == P_LOAD) ? 1'b1 : (ph == P_PIX) ? !af : 1'b0;
    if (!r) begin
      chk("s_ready", s_ready, e_rdy);
      chk("busy_pre", busy, ph != P_IDLE);
    end
    acc = v && e_rdy && !r;
    @(posedge clk); #1;
    cyc++;
    e_wen = 0; e_iv = 0; e_done = 0;
    if (r) begin
      ph = P_IDLE; m_loaded = 0; m_n = 0;
      e_waddr = '0; e_wdata = '0; e_idata = '0; e_fc = '0;
    end else begin
      case (ph)
        P_IDLE: if (st) begin
          m_n = 0;
          ph  = (rl || !m_loaded) ? P_LOAD : P_PIX;
        end
        P_LOAD: if (acc) begin
          e_wen = 1; e_waddr = AW'(m_n); e_wdata = d; m_n++;
          if (m_n == WC) begin m_loaded = 1; ph = P_GAP; m_gap = SC; end
        end
        P_GAP: begin
          m_gap--;
          if (m_gap == 0) begin ph = P_PIX; m_n = 0; end
        end
        P_PIX: if (acc) begin
          e_iv = 1; e_idata = d; m_n++;
          if (m_n == IS) ph = P_END;
        end
        P_END: begin ph = P_IDLE; e_done = 1; e_fc = e_fc + 16'd1; end
        default: ph = P_IDLE;
      endcase
    end
    chk("wr_en", weight_wr_en, e_wen);
    chk("wr_addr", weight_wr_addr, e_waddr);
    chk("wr_data", weight_wr_data, e_wdata);
    chk("i_valid", i_valid, e_iv);
    chk("i_data", i_data, e_idata);
    chk("done", done, e_done);
    chk("frame_cnt", frame_cnt, e_fc);
    chk("busy_post", busy, ph != P_IDLE);
    if (weight_wr_en === 1'b1) begin last_wr_cyc = cyc; n_wr++; end
    if (i_valid === 1'b1) begin
      if (first_pix_cyc < 0) first_pix_cyc = cyc;
      n_pix++;
    end
    if (done === 1'b1) done_seen++;
  endtask

  // Test-plan data pattern: 72 x 1, 4 x 10, one 0x0100, then pixels of 100.
  function automatic logic [DW-1:0] pat();
    if (ph == P_LOAD) return (m_n < 72) ? 16'd1 : (m_n < 76) ? 16'd10 : 16'h0100;
    return 16'd100;
  endfunction

  // vmode: 0 valid held, 1 valid toggling, 2 random. afmode: 0 none,
  // 1 five-cycle stall at pixel 12, 2 random. stray: extra start at that pixel.
  // abort_at: reset after that many weights.
  task automatic run_frame(input bit rl, input int vmode, input int afmode, input int stray,
                           input int abort_at, input bit fixed, input bit gap_chk);
    bit acc, v, af, st, stray_done, bp_done, was_load;
    int guard, bp_left;
    logic [DW-1:0] cur;
    cur = DW'($urandom);
    last_wr_cyc = -1; first_pix_cyc = -1; done_seen = 0; n_wr = 0; n_pix = 0;
    stray_done = 0; bp_done = 0; bp_left = 0; guard = 0;
    tick(1'b1, rl, 1'b0, 1'b0, 1'b0, cur, acc);
    was_load = (ph == P_LOAD);
    while (ph != P_IDLE && guard < 3000) begin
      guard++;
      if (abort_at >= 0 && ph == P_LOAD && m_n == abort_at) begin
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, cur, acc);
        chk("abort_wr_count", n_wr, abort_at);
        return;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = guard[0];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      af = 1'b0;
      if (afmode == 1) begin
        if (ph == P_PIX && m_n == 12 && !bp_done) begin bp_left = 5; bp_done = 1; end
        if (bp_left > 0) begin af = 1'b1; bp_left--; end
      end else if (afmode == 2) begin
        af = ($urandom_range(0, 3) == 0);
      end
      st = 1'b0;
      if (stray >= 0 && !stray_done && ph == P_PIX && m_n == stray) begin
        st = 1'b1; stray_done = 1;
      end
      if (ph == P_END && vmode == 2) st = ($urandom_range(0, 1) == 1);
      if (fixed) cur = pat();
      tick(st, ($urandom_range(0, 1) == 1), v, af, 1'b0, cur, acc);
      if (acc && !fixed) cur = DW'($urandom);
    end
    chk("frame_timeout", guard < 3000, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur, acc);
    chk("done_pulses", done_seen, 1);
    chk("wr_count", n_wr, was_load ? WC : 0);
    chk("pix_count", n_pix, IS);
    if (gap_chk) chk("settle_gap", first_pix_cyc - last_wr_cyc, SC + 1);
    if (!was_load) chk("warm_no_gap", first_pix_cyc > 0, 1);
  endtask

  initial begin
    bit acc;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, acc);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, acc);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, acc);
    chk("reset_frame_cnt", frame_cnt, 0);

    // cold load with the reference data pattern
    run_frame(1'b0, 0, 0, -1, -1, 1'b1, 1'b1);
    chk("cold_frame_cnt", frame_cnt, 1);
    // warm frame: no load, no settle
    run_frame(1'b0, 0, 0, -1, -1, 1'b0, 1'b0);
    chk("warm_frame_cnt", frame_cnt, 2);
    // backpressure at pixel 12
    run_frame(1'b0, 0, 1, -1, -1, 1'b0, 1'b0);
    // forced reload with bubbles on the input
    run_frame(1'b1, 1, 0, -1, -1, 1'b0, 1'b0);
    // reset after 40 weights, then a start without reload must load fully
    run_frame(1'b1, 0, 0, -1, 40, 1'b0, 1'b0);
    chk("abort_frame_cnt", frame_cnt, 0);
    run_frame(1'b0, 0, 0, -1, -1, 1'b0, 1'b1);
    chk("post_abort_frame_cnt", frame_cnt, 1);
    // stray start while streaming
    run_frame(1'b0, 0, 0, 8, -1, 1'b0, 1'b0);
    // randomized frames
    for (int f = 0; f < 8; f++)
      run_frame(($urandom_range(0, 1) == 1), 2, 2, $urandom_range(0, IS - 1), -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
